// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: word width, default memory geometry,
// FSM state encodings and the header range check.
package prog_loader_pkg;

    localparam int WORD_W     = 16;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HI   = 3'd1;
    localparam logic [2:0] ST_LO   = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } word_t;

    // A header is usable when it names between 1 and depth words.
    function automatic logic hdr_ok(input logic [7:0] n, input int depth);
        return (n != 8'd0) && (int'({24'd0, n}) <= depth);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, program RAM write port and core-control status out.
interface prog_loader_if #(parameter int ADDR_W = 5);

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_rstn;
    logic              done;
    logic              err;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_rstn, done, err
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, cpu_rstn, done, err
    );

endinterface

// File: rtl/prog_loader_word_asm.sv
// Pairs high/low stream bytes into one instruction word and issues a registered
// single-cycle RAM write the cycle after the low byte arrives.
module loader_word_asm
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        dat_i,
    input  logic              hi_take_i,
    input  logic              lo_take_i,
    input  logic [ADDR_W-1:0] idx_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [WORD_W-1:0] wr_data_o
);

    logic [7:0]        hi_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    word_t             wr_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= lo_take_i;
            if (hi_take_i)
                hi_q <= dat_i;
            // Address and data hold their last value between writes.
            if (lo_take_i) begin
                wr_addr_q <= idx_i;
                wr_data_q <= '{hi: hi_q, lo: dat_i};
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: header N, 2N payload bytes, optional XOR checksum
// (enabled by defining CHECKSUM_EN). Holds the core in reset until an image completes.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              rdy_q;
    logic              xfer;
    logic              hi_take, lo_take;

    assign xfer = bus.in_valid & rdy_q;

`ifdef CHECKSUM_EN
    logic [7:0] xor_q;

    // Running XOR restarts on every accepted header, then folds in the payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xor_q <= '0;
        else if (xfer) begin
            if (state_q == ST_IDLE || state_q == ST_DONE)
                xor_q <= bus.in_data;
            else if (state_q == ST_HI || state_q == ST_LO)
                xor_q <= xor_q ^ bus.in_data;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        hi_take = 1'b0;
        lo_take = 1'b0;
        if (xfer) begin
            case (state_q)
                // A byte arriving after a completed load starts a new image.
                ST_IDLE, ST_DONE: begin
                    if (hdr_ok(bus.in_data, DEPTH)) begin
                        state_d = ST_HI;
                        idx_d   = '0;
                        last_d  = ADDR_W'(bus.in_data - 8'd1);
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                ST_HI: begin
                    hi_take = 1'b1;
                    state_d = ST_LO;
                end
                ST_LO: begin
                    lo_take = 1'b1;
                    if (idx_q == last_q) begin
`ifdef CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_HI;
                    end
                end
`ifdef CHECKSUM_EN
                ST_CHK: state_d = (bus.in_data == xor_q) ? ST_DONE : ST_ERR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            rdy_q   <= (state_d != ST_ERR);
        end
    end

    loader_word_asm #(.ADDR_W(ADDR_W)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .dat_i     (bus.in_data),
        .hi_take_i (hi_take),
        .lo_take_i (lo_take),
        .idx_i     (idx_q),
        .wr_en_o   (bus.wr_en),
        .wr_addr_o (bus.wr_addr),
        .wr_data_o (bus.wr_data)
    );

    assign bus.in_ready = rdy_q;
    assign bus.cpu_rstn = (state_q == ST_DONE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.err      = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized-gap stimulus for prog_loader checked every cycle against a frame-level model.
module tb_prog_loader;

    localparam int AW    = 5;
    localparam int DEPTH = 16;

    typedef struct {
        int due;
        int addr;
        int data;
    } ew_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(AW)) bus ();
    prog_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // model state: position inside the current frame, declared size, xor, pending high byte
    int         pos = 0;
    int         m_n = 0;
    logic [7:0] m_x = '0;
    logic [7:0] m_hi = '0;
    bit exp_rstn = 0, exp_done = 0, exp_err = 0, exp_rdy = 0;
    int  cyc = 0;
    ew_t expq[$];
    logic [15:0] ram [0:31];

    always @(posedge clk) if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = 0; m_x = '0;
        exp_rstn = 0; exp_done = 0; exp_err = 0; exp_rdy = 0;
        expq.delete();
    endtask

    // Called right after the clock edge on which byte b was transferred.
    task automatic model_accept(input logic [7:0] b);
        ew_t w;
        if (pos == 0) begin
            exp_rstn = 0; exp_done = 0;
            if (b == 0 || int'(b) > DEPTH) begin
                exp_err = 1; exp_rdy = 0;
            end else begin
                m_n = int'(b); m_x = b; pos = 1;
            end
        end else if (pos <= 2 * m_n) begin
            m_x = m_x ^ b;
            if (pos % 2 == 1) m_hi = b;
            else begin
                w.due = cyc + 1; w.addr = pos / 2 - 1; w.data = int'({m_hi, b});
                expq.push_back(w);
            end
            if (pos == 2 * m_n) begin
`ifdef CHECKSUM_EN
                pos = pos + 1;
`else
                pos = 0; exp_rstn = 1; exp_done = 1;
`endif
            end else pos = pos + 1;
        end else begin
            pos = 0;
            if (b == m_x) begin exp_rstn = 1; exp_done = 1; end
            else begin exp_err = 1; exp_rdy = 0; end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                check("wr_en", 32'(bus.wr_en), 1);
                check("wr_addr", 32'(bus.wr_addr), expq[0].addr);
                check("wr_data", 32'(bus.wr_data), expq[0].data);
                expq.delete(0);
            end else begin
                check("wr_en_idle", 32'(bus.wr_en), 0);
            end
            check("cpu_rstn", 32'(bus.cpu_rstn), 32'(exp_rstn));
            check("done", 32'(bus.done), 32'(exp_done));
            check("err", 32'(bus.err), 32'(exp_err));
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit r, ok;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            r = bus.in_ready;
            @(posedge clk);
            if (r) begin
                ok = 1;
                model_accept(b);
            end else @(negedge clk);
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Asserts reset between edges and confirms the outputs clear without a clock.
    task automatic do_reset();
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_wr_en", 32'(bus.wr_en), 0);
        check("rst_async_rstn", 32'(bus.cpu_rstn), 0);
        check("rst_async_done", 32'(bus.done), 0);
        check("rst_async_rdy", 32'(bus.in_ready), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        exp_rdy = 1;
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] fr[$]);
        logic [7:0] x = '0;
        foreach (fr[i]) x = x ^ fr[i];
        return x;
    endfunction

    task automatic send_frame(input logic [7:0] fr[$], input bit gaps);
        logic [7:0] ck;
        ck = xor_of(fr);
        foreach (fr[i]) send_byte(fr[i], gaps ? $urandom_range(0, 5) : 0);
`ifdef CHECKSUM_EN
        send_byte(ck, gaps ? $urandom_range(0, 5) : 0);
`else
        if (ck == 8'hFF) total = total + 0;
`endif
    endtask

    initial begin
        logic [7:0] t1[$], fr[$];
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1 rst = 1'b1;
        do_reset();

        // example image, back to back
        t1 = '{8'h04, 8'h0A, 8'h02, 8'h4B, 8'h00, 8'h44, 8'h05, 8'h4B, 8'h00};
        send_frame(t1, 0);
        idle(3);
        check("t1_ram0", 32'(ram[0]), 32'h0A02);
        check("t1_ram1", 32'(ram[1]), 32'h4B00);
        check("t1_ram2", 32'(ram[2]), 32'h4405);
        check("t1_ram3", 32'(ram[3]), 32'h4B00);
        check("t1_done", 32'(bus.done), 1);
        check("t1_rstn", 32'(bus.cpu_rstn), 1);

        // bad headers: zero and one past depth
        do_reset();
        send_byte(8'h00, 0);
        idle(3);
        check("hdr00_err", 32'(bus.err), 1);
        check("hdr00_rdy", 32'(bus.in_ready), 0);
        do_reset();
        send_byte(8'h11, 1);
        idle(3);
        check("hdr11_err", 32'(bus.err), 1);
        check("hdr11_rstn", 32'(bus.cpu_rstn), 0);

`ifdef CHECKSUM_EN
        // wrong checksum after a full image
        do_reset();
        foreach (t1[i]) send_byte(t1[i], 0);
        send_byte(8'h4C, 0);
        idle(3);
        check("badck_err", 32'(bus.err), 1);
        check("badck_rstn", 32'(bus.cpu_rstn), 0);
`endif

        // same image with random gaps
        do_reset();
        send_frame(t1, 1);
        idle(2);

        // reset mid-frame, then a one-word image
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(t1[i], 0);
        do_reset();
        fr = '{8'h01, 8'h12, 8'h34};
        send_frame(fr, 1);
        idle(2);
        check("t5_ram0", 32'(ram[0]), 32'h1234);
        check("t5_done", 32'(bus.done), 1);

        // reload straight out of DONE
        fr = '{8'h01, 8'hAB, 8'hCD};
        send_frame(fr, 0);
        idle(2);
        check("t6_ram0", 32'(ram[0]), 32'hABCD);
        check("t6_rstn", 32'(bus.cpu_rstn), 1);

        // random images chained through DONE, first one full depth
        for (int f = 0; f < 6; f++) begin
            n = (f == 0) ? DEPTH : $urandom_range(1, DEPTH);
            fr.delete();
            fr.push_back(8'(n));
            for (int i = 0; i < 2 * n; i++) fr.push_back(8'($urandom));
            send_frame(fr, 1);
            idle($urandom_range(0, 3));
        end

        // random oversize header out of DONE
        send_byte(8'($urandom_range(DEPTH + 1, 255)), 2);
        idle(3);
        check("big_hdr_err", 32'(bus.err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
